noc_link_buffer: RTL

NOC_LINK_BUFFER -- requirements
Module: noc_link_buffer

---
 rtl/noc_link_buffer.sv | 92 +++++++++
 1 files changed

// File: rtl/noc_link_buffer.sv
// noc_link_buffer: first-word fall-through link FIFO with optional packet-protocol checker.
// Define RAVENOC_LINK_PKT_CHK_EN to build the packet FSM, err_o and pkt_open_o.
module noc_link_buffer #(
    parameter int FLIT_WIDTH = 34,
    parameter int DEPTH      = 4
) (
    input  logic                       clk_noc,
    input  logic                       arst_noc,
    input  logic [FLIT_WIDTH-1:0]      flit_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output logic [FLIT_WIDTH-1:0]      flit_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       err_o,
    input  logic                       err_clr_i,
    output logic                       pkt_open_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [FLIT_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr, rd_ptr;
    logic                  push, pop;

    // Extra pointer MSB separates full from empty, so the difference is the occupancy.
    assign count_o = wr_ptr - rd_ptr;
    assign ready_o = count_o != CW'(DEPTH);
    assign valid_o = count_o != '0;
    assign push    = valid_i && ready_o;
    assign pop     = valid_o && ready_i;
    assign flit_o  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_noc or negedge arst_noc) begin
        if (!arst_noc) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_noc) begin
        if (push) mem[wr_ptr[AW-1:0]] <= flit_i;
    end

`ifdef RAVENOC_LINK_PKT_CHK_EN
    typedef enum logic [1:0] {HEAD = 2'b00, BODY = 2'b01, TAIL = 2'b10, HEAD_TAIL = 2'b11} flit_type_t;
    typedef enum logic {IDLE, IN_PKT} pkt_state_t;

    pkt_state_t state, state_nxt;
    flit_type_t ftype;
    logic       err_set, err_q;

    assign ftype = flit_type_t'(flit_i[FLIT_WIDTH-1 -: 2]);

    // Only accepted flits advance the checker; offending flits leave the state as is.
    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        if (push) begin
            if (state == IDLE) begin
                state_nxt = (ftype == HEAD) ? IN_PKT : IDLE;
                err_set   = (ftype == BODY) || (ftype == TAIL);
            end else begin
                state_nxt = (ftype == TAIL) ? IDLE : IN_PKT;
                err_set   = (ftype == HEAD) || (ftype == HEAD_TAIL);
            end
        end
    end

    always_ff @(posedge clk_noc or negedge arst_noc) begin
        if (!arst_noc) begin
            state <= IDLE;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= err_set ? 1'b1 : (err_clr_i ? 1'b0 : err_q);
        end
    end

    assign err_o      = err_q;
    assign pkt_open_o = state == IN_PKT;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr_i;
    assign err_o          = 1'b0;
    assign pkt_open_o     = 1'b0;
`endif
endmodule
